// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline constants: load/store funct3 encodings and access-size decode.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Unused encodings fall through to a full-word access.
  function automatic size_e f3_size(logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SZ_B;
      F3_LH, F3_LHU: f3_size = SZ_H;
      default:       f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Data memory split into four byte lanes: per-lane synchronous write, async read.
module dmem_bytelane #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [WORDS];

    always_ff @(posedge clk)
      if (be[l]) mem[addr] <= wdata[8*l +: 8];

    assign rdata[8*l +: 8] = mem[addr];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data access (byte-enabled stores, extending loads) and the MEM/WB register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EXMEM_alu_result,
  input  logic [31:0] EXMEM_store_data,
  input  logic [4:0]  EXMEM_rd,
  input  logic [2:0]  EXMEM_funct3,
  input  logic        EXMEM_WriteBack,
  input  logic        EXMEM_MemoryRead,
  input  logic        EXMEM_MemoryWrite,
  output logic        MEMWB_WriteBack,
  output logic [4:0]  MEMWB_rd,
  output logic [31:0] MEMEX_WriteBack,
  output logic        misaligned
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [1:0]    off;
  logic [AW-1:0] idx;
  size_e         sz;
  logic [3:0]    be;
  logic [31:0]   wdata, rdata, load_data;
  logic          mis;
  logic [7:0]    b;
  logic [15:0]   h;

  assign off = EXMEM_alu_result[1:0];
  assign idx = EXMEM_alu_result[AW+1:2];
  assign sz  = f3_size(EXMEM_funct3);

  always_comb begin
    mis   = 1'b0;
    be    = 4'b1111;
    wdata = EXMEM_store_data;
    case (sz)
      SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{EXMEM_store_data[7:0]}};
      end
      SZ_H: begin
        mis   = off[0];
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{EXMEM_store_data[15:0]}};
      end
      default: mis = (off != 2'b00);
    endcase
  end

  dmem_bytelane #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
    .clk   (clk),
    .be    ((EXMEM_MemoryWrite && !mis && !reset) ? be : 4'b0000),
    .addr  (idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (EXMEM_funct3)
      F3_LB:   load_data = {{24{b[7]}}, b};
      F3_LBU:  load_data = {24'h0, b};
      F3_LH:   load_data = {{16{h[15]}}, h};
      F3_LHU:  load_data = {16'h0, h};
      default: load_data = rdata;
    endcase
    if (mis) load_data = '0;
  end

  // A combined read+write is treated as a store, so it never writes the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MEMWB_WriteBack <= 1'b0;
      MEMWB_rd        <= '0;
      MEMEX_WriteBack <= '0;
      misaligned      <= 1'b0;
    end else begin
      MEMWB_WriteBack <= EXMEM_WriteBack && (EXMEM_rd != 5'd0) && !EXMEM_MemoryWrite;
      MEMWB_rd        <= EXMEM_rd;
      MEMEX_WriteBack <= EXMEM_MemoryRead ? load_data : EXMEM_alu_result;
      misaligned      <= (EXMEM_MemoryRead || EXMEM_MemoryWrite) && mis;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed checks of mem_wb_stage: loads/stores, extension, misalignment, x0, reset.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu, sd;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        wb, mr, mw;
  logic        o_wb, o_mis;
  logic [4:0]  o_rd;
  logic [31:0] o_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DMEM_WORDS(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .EXMEM_alu_result  (alu),
    .EXMEM_store_data  (sd),
    .EXMEM_rd          (rd),
    .EXMEM_funct3      (f3),
    .EXMEM_WriteBack   (wb),
    .EXMEM_MemoryRead  (mr),
    .EXMEM_MemoryWrite (mw),
    .MEMWB_WriteBack   (o_wb),
    .MEMWB_rd          (o_rd),
    .MEMEX_WriteBack   (o_data),
    .misaligned        (o_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one EX/MEM beat, clock it, land 1 time unit after the edge.
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                      input logic [2:0] f, input logic w, input logic rdm, input logic wrm);
    alu = a; sd = d; rd = r; f3 = f; wb = w; mr = rdm; mw = wrm;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    beat(a, d, 5'd0, f, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r, input logic [2:0] f);
    beat(a, 32'h0, r, f, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    alu = '0; sd = '0; rd = '0; f3 = '0; wb = 1'b0; mr = 1'b0; mw = 1'b0;
    #1;
    chk("rst_wb",   {31'h0, o_wb},  32'h0);
    chk("rst_rd",   {27'h0, o_rd},  32'h0);
    chk("rst_data", o_data,         32'h0);
    chk("rst_mis",  {31'h0, o_mis}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    store(32'h10, 32'hDEADBEEF, 3'b010);
    chk("sw_wb",  {31'h0, o_wb},  32'h0);
    chk("sw_mis", {31'h0, o_mis}, 32'h0);
    load(32'h10, 5'd5, 3'b010);
    chk("lw_wb",   {31'h0, o_wb}, 32'h1);
    chk("lw_rd",   {27'h0, o_rd}, 32'd5);
    chk("lw_data", o_data,        32'hDEADBEEF);

    load(32'h13, 5'd1, 3'b000); chk("lb_13",  o_data, 32'hFFFFFFDE);
    load(32'h13, 5'd1, 3'b100); chk("lbu_13", o_data, 32'h000000DE);
    load(32'h12, 5'd1, 3'b001); chk("lh_12",  o_data, 32'hFFFFDEAD);
    load(32'h10, 5'd1, 3'b101); chk("lhu_10", o_data, 32'h0000BEEF);
    load(32'h10, 5'd1, 3'b000); chk("lb_10",  o_data, 32'hFFFFFFEF);
    load(32'h11, 5'd1, 3'b100); chk("lbu_11", o_data, 32'h000000BE);

    store(32'h11, 32'hAAAAAA55, 3'b000);
    load(32'h10, 5'd2, 3'b010); chk("sb_lw", o_data, 32'hDEAD55EF);
    store(32'h12, 32'h9999CAFE, 3'b001);
    load(32'h10, 5'd2, 3'b010); chk("sh_lw", o_data, 32'hCAFE55EF);

    store(32'h20, 32'h01020304, 3'b010);
    store(32'h22, 32'h12345678, 3'b010);
    chk("sw_mis_flag", {31'h0, o_mis}, 32'h1);
    load(32'h20, 5'd3, 3'b010);
    chk("sw_mis_mem",  o_data,         32'h01020304);
    chk("mis_clear",   {31'h0, o_mis}, 32'h0);
    load(32'h21, 5'd7, 3'b001);
    chk("lh_mis_data", o_data,         32'h0);
    chk("lh_mis_flag", {31'h0, o_mis}, 32'h1);
    store(32'h23, 32'hFFFFFFFF, 3'b001);
    load(32'h20, 5'd3, 3'b010); chk("sh_mis_mem", o_data, 32'h01020304);

    beat(32'h42, 32'h0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("x0_wb", {31'h0, o_wb}, 32'h0);
    beat(32'h42, 32'h0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("alu_wb",   {31'h0, o_wb}, 32'h1);
    chk("alu_data", o_data,        32'h42);

    beat(32'h30, 32'h11111111, 5'd4, 3'b010, 1'b1, 1'b1, 1'b1);
    chk("rw_wb", {31'h0, o_wb}, 32'h0);
    load(32'h30, 5'd6, 3'b010); chk("rw_mem", o_data, 32'h11111111);
    store(32'h30, 32'h22222222, 3'b010);
    load(32'h30, 5'd6, 3'b010); chk("ld_after_st", o_data, 32'h22222222);

    store(32'h34, 32'hA5A5A5A5, 3'b011);
    load(32'h34, 5'd8, 3'b111); chk("f3_unsup", o_data, 32'hA5A5A5A5);
    load(32'h410, 5'd8, 3'b010); chk("addr_wrap", o_data, 32'hCAFE55EF);

    load(32'h10, 5'd5, 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wb",   {31'h0, o_wb},  32'h0);
    chk("mid_rst_rd",   {27'h0, o_rd},  32'h0);
    chk("mid_rst_data", o_data,         32'h0);
    store(32'h10, 32'h00000000, 3'b010);
    chk("rst_hold", o_data, 32'h0);
    reset = 1'b0;
    load(32'h10, 5'd5, 3'b010);
    chk("rst_mem_kept", o_data, 32'hCAFE55EF);
    chk("rst_resume_rd", {27'h0, o_rd}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
